anc_frame_tx: RTL

- Output-side serializer for the ANC path: captures one ANC output sample and one error/reference difference sample per sample strobe.
- Packs both samples into a fixed byte frame and transmits it LSB-first as UART 8N1 on txd.
- Runs in the clkdv domain, downstream of the ANC core, and feeds the host/PC link.

---
 rtl/anc_frame_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/anc_frame_tx.sv
// anc_frame_tx: packs one ANC output sample and one Sn-Rn sample per strobe into a byte
// frame sent LSB-first as UART 8N1. Define ANC_TX_CSUM_EN to append a checksum byte.
module anc_frame_tx #(
  parameter int unsigned W1           = 24,
  parameter int unsigned CLKS_PER_BIT = 5,
  parameter logic [7:0]  HDR          = 8'hA5
) (
  input  logic          clkdv,
  input  logic          reset,
  input  logic          en,
  input  logic          sample_valid,
  input  logic [W1-1:0] ancin,
  input  logic [W1-1:0] xnin,
  output logic          txd,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    drop_cnt
);

  localparam int unsigned SampBytes = W1 / 8;
`ifdef ANC_TX_CSUM_EN
  localparam int unsigned NumBytes  = 3 + 2 * SampBytes;
`else
  localparam int unsigned NumBytes  = 2 + 2 * SampBytes;
`endif
  localparam int unsigned RestW     = (NumBytes - 1) * 8;
  localparam int unsigned BaudW     = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned ByteW     = $clog2(NumBytes);

  localparam logic [BaudW-1:0] BaudLast  = BaudW'(CLKS_PER_BIT - 1);
  // The first start bit waits one extra cycle so it appears on the edge after capture.
  localparam logic [BaudW-1:0] BaudFirst = BaudW'(CLKS_PER_BIT);
  localparam logic [ByteW-1:0] ByteLast  = ByteW'(NumBytes - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

  state_e           state;
  logic [BaudW-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [ByteW-1:0] byte_cnt;
  logic [7:0]       shreg;
  logic [RestW-1:0] rest;
  logic [7:0]       seq;
  logic [RestW-1:0] capture_bytes;

`ifdef ANC_TX_CSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = seq;
    for (int i = 0; i < int'(SampBytes); i++) begin
      csum = csum + ancin[8*i +: 8] + xnin[8*i +: 8];
    end
  end

  assign capture_bytes = {seq, ancin, xnin, csum};
`else
  assign capture_bytes = {seq, ancin, xnin};
`endif

  always_ff @(posedge clkdv) begin
    if (reset) begin
      state      <= StIdle;
      txd        <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= 8'd0;
      seq        <= 8'd0;
      baud_cnt   <= '0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= '0;
      shreg      <= 8'd0;
      rest       <= '0;
    end else begin
      if (sample_valid && (busy || state == StDone) && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      unique case (state)
        StIdle: begin
          if (en && sample_valid) begin
            shreg    <= HDR;
            rest     <= capture_bytes;
            byte_cnt <= '0;
            baud_cnt <= BaudFirst;
            busy     <= 1'b1;
            state    <= StStart;
          end
        end
        StStart: begin
          txd <= 1'b0;
          if (baud_cnt == '0) begin
            txd      <= shreg[0];
            bit_cnt  <= 3'd0;
            baud_cnt <= BaudLast;
            state    <= StData;
          end else begin
            baud_cnt <= baud_cnt - BaudW'(1);
          end
        end
        StData: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BaudLast;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= StStop;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              txd     <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - BaudW'(1);
          end
        end
        StStop: begin
          if (baud_cnt == '0) begin
            if (byte_cnt == ByteLast) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= StDone;
            end else begin
              // Next byte starts immediately: no idle gap between bytes.
              byte_cnt <= byte_cnt + ByteW'(1);
              shreg    <= rest[RestW-1 -: 8];
              rest     <= {rest[RestW-9:0], 8'h00};
              txd      <= 1'b0;
              baud_cnt <= BaudLast;
              state    <= StStart;
            end
          end else begin
            baud_cnt <= baud_cnt - BaudW'(1);
          end
        end
        StDone: begin
          frame_done <= 1'b0;
          seq        <= seq + 8'd1;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
